// File: rtl/math_add_48_arb_if.sv
// Request/response bundle for the shared 48-bit adder arbiter.
// Requesters own the master side; the arbiter is the slave.
interface math_add_48_arb_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [48*NUM_REQ-1:0] req_dina;
  logic [48*NUM_REQ-1:0] req_dinb;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [48:0]           rsp_dout;
  logic [IDW:0]          inflight;

  modport master (
    output req_valid,
    output req_dina,
    output req_dinb,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_dout,
    input  inflight
  );

  modport slave (
    input  req_valid,
    input  req_dina,
    input  req_dinb,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_dout,
    output inflight
  );
endinterface

// File: rtl/math_add_48_arb.sv
// Round-robin arbiter time-sharing one 48-bit adder among
// NUM_REQ requesters, with a tag pipeline matching adder latency.
module math_add_48 #(
  parameter int USE_FABRIC  = 0,
  parameter int FLOP_INPUTS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [47:0] dina,
  input  logic [47:0] dinb,
  output logic [48:0] dout
);
  if (USE_FABRIC != 0 && FLOP_INPUTS != 0) begin : g_cfg_err
    $error("FLOP_INPUTS must be 0 when USE_FABRIC = 1");
  end

  logic [47:0] a;
  logic [47:0] b;

  if (FLOP_INPUTS != 0) begin : g_fi
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a <= '0;
        b <= '0;
      end else if (ena) begin
        a <= dina;
        b <= dinb;
      end
    end
  end else begin : g_nfi
    assign a = dina;
    assign b = dinb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (ena) begin
      dout <= {1'b0, a} + {1'b0, b};
    end
  end
endmodule

module math_add_48_arb #(
  parameter int NUM_REQ     = 4,
  parameter int USE_FABRIC  = 0,
  parameter int FLOP_INPUTS = 1
) (
  input logic              clk,
  input logic              rst,
  input logic              ena,
  math_add_48_arb_if.slave bus
);
  localparam int IDW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAT = 1 + FLOP_INPUTS;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_nreq_err
    $error("NUM_REQ must be in 2..16");
  end

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW:0]   idx;
  logic           found;
  logic           take;
  int             gi;
  logic [47:0]    add_a;
  logic [47:0]    add_b;
  tag_t           tags [LAT];
  tag_t           tail;
  logic [IDW-1:0] id_q;
  logic [IDW:0]   cnt;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ))
        idx = idx - (IDW+1)'(NUM_REQ);
      if (!found && bus.req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = idx[IDW-1:0];
      end
    end
  end

  assign take = found & ena & ~rst;

  always_comb begin
    bus.req_ready = '0;
    if (take) bus.req_ready[grant] = 1'b1;
  end

  assign gi    = 48 * int'(grant);
  assign add_a = bus.req_dina[gi +: 48];
  assign add_b = bus.req_dinb[gi +: 48];

  math_add_48 #(
    .USE_FABRIC  (USE_FABRIC),
    .FLOP_INPUTS (FLOP_INPUTS)
  ) u_add (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .dina (add_a),
    .dinb (add_b),
    .dout (bus.rsp_dout)
  );

  // tags advance only with ena so they track the adder stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < LAT; i++) tags[i] <= '0;
    end else if (ena) begin
      tags[0] <= '{v: take, id: grant};
      for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
      if (take)
        rr_ptr <= (grant == IDW'(NUM_REQ - 1)) ?
                  '0 : grant + 1'b1;
    end
  end

  assign tail = tags[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_q <= '0;
    else if (tail.v) id_q <= tail.id;
  end

  assign bus.rsp_id = tail.v ? tail.id : id_q;

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.rsp_valid[i] = ena & tail.v &
                         (tail.id == IDW'(i));
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < LAT; i++)
      cnt = cnt + (IDW+1)'(tags[i].v);
  end

  assign bus.inflight = cnt;
endmodule

// File: tb/tb_math_add_48_arb.sv
// Randomized and directed checks of math_add_48_arb against a
// queue-based model of accepted pairs and their ages.
module tb_math_add_48_arb;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ena   = 1'b0;
  logic ena_f = 1'b0;
  int checks  = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  math_add_48_arb_if #(.NUM_REQ(N)) bus ();
  math_add_48_arb_if #(.NUM_REQ(N)) fbus ();

  math_add_48_arb #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  math_add_48_arb #(
    .NUM_REQ     (N),
    .USE_FABRIC  (1),
    .FLOP_INPUTS (0)
  ) fdut (
    .clk (clk),
    .rst (rst),
    .ena (ena_f),
    .bus (fbus)
  );

  typedef struct {
    int          id;
    logic [48:0] sum;
    int          age;
  } ent_t;

  ent_t q[$];
  int   m_ptr   = 0;
  int   last_id = 0;

  function automatic int grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = grant();
    if (rst || !ena || g < 0) return '0;
    return N'(1) << g;
  endfunction

  function automatic int shown();
    foreach (q[i]) if (q[i].age == LAT) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rsp();
    int s;
    s = shown();
    if (!ena || s < 0) return '0;
    return N'(1) << q[s].id;
  endfunction

  function automatic logic [1:0] exp_id();
    int s;
    s = shown();
    return (s >= 0) ? 2'(q[s].id) : 2'(last_id);
  endfunction

  function automatic logic [48:0] exp_dout();
    int s;
    s = shown();
    return (s >= 0) ? q[s].sum : '0;
  endfunction

  function automatic logic [2:0] exp_infl();
    return 3'(q.size());
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) return '1;
    return r[47:0];
  endfunction

  // advance the model by one clock edge using pre-edge inputs
  task automatic model_step();
    int g;
    if (rst) begin
      q.delete();
      m_ptr   = 0;
      last_id = 0;
    end else if (ena) begin
      g = grant();
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].age == LAT) begin
          last_id = q[i].id;
          q.delete(i);
        end
      foreach (q[i]) q[i].age++;
      if (g >= 0) begin
        q.push_back('{g,
          {1'b0, bus.req_dina[48*g +: 48]} +
          {1'b0, bus.req_dinb[48*g +: 48]}, 1});
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    ena = 1'b1;
    bus.req_valid = '1;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id,
         bus.inflight} !== 15'd0) begin
      errors++;
      $display("FAIL reset rdy/rsp/id/infl got %b/%b/%0d/%0d need 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id,
               bus.inflight);
    end
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_fairness();
    ena = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.req_dina[48*i +: 48] = rnd48();
      bus.req_dinb[48*i +: 48] = rnd48();
    end
    for (int c = 0; c < 12; c++) begin
      bus.req_valid = (c < 8) ? '1 : '0;
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (bus.req_ready !== (N'(1) << (c % N))) begin
          errors++;
          $display("FAIL fair_grant c%0d got %b need %b", c,
                   bus.req_ready, N'(1) << (c % N));
        end
      end
      checks++;
      if ({bus.rsp_valid, bus.inflight} !==
          {exp_rsp(), exp_infl()}) begin
        errors++;
        $display("FAIL fair_rsp c%0d got %b/%0d need %b/%0d", c,
                 bus.rsp_valid, bus.inflight, exp_rsp(),
                 exp_infl());
      end
      if (exp_rsp() != '0) begin
        checks++;
        if ({bus.rsp_id, bus.rsp_dout} !==
            {exp_id(), exp_dout()}) begin
          errors++;
          $display("FAIL fair_data c%0d got %0d/%h need %0d/%h", c,
                   bus.rsp_id, bus.rsp_dout, exp_id(), exp_dout());
        end
      end
      tick();
      for (int i = 0; i < N; i++)
        if (c < 8 && (c % N) == i) begin
          bus.req_dina[48*i +: 48] = rnd48();
          bus.req_dinb[48*i +: 48] = rnd48();
        end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] rv [4];
    logic [2:0]   fl [4];
    rv = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    fl = '{3'd0, 3'd1, 3'd1, 3'd0};
    ena = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_dina[96 +: 48] = 48'h0000_0000_0005;
    bus.req_dinb[96 +: 48] = 48'h0000_0000_0007;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.inflight} !== {rv[c], fl[c]}) begin
        errors++;
        $display("FAIL single c%0d rsp/infl got %b/%0d need %b/%0d",
                 c, bus.rsp_valid, bus.inflight, rv[c], fl[c]);
      end
      if (c == 0) begin
        checks++;
        if (bus.req_ready !== 4'b0100) begin
          errors++;
          $display("FAIL single_ready got %b need 0100",
                   bus.req_ready);
        end
      end
      if (c == 2) begin
        checks++;
        if ({bus.rsp_id, bus.rsp_dout} !==
            {2'd2, 49'h0_0000_0000_000C}) begin
          errors++;
          $display("FAIL single_data got %0d/%h need 2/c",
                   bus.rsp_id, bus.rsp_dout);
        end
      end
      tick();
      bus.req_valid = '0;
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] rq [3];
    logic [N-1:0] gr [3];
    rq = '{4'b0010, 4'b1010, 4'b0010};
    gr = '{4'b0010, 4'b1000, 4'b0010};
    ena = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = rq[c];
      @(negedge clk);
      checks++;
      if (bus.req_ready !== gr[c]) begin
        errors++;
        $display("FAIL wrap c%0d ready got %b need %b", c,
                 bus.req_ready, gr[c]);
      end
      tick();
    end
    idle(3);
  endtask

  task automatic test_stall();
    int ids [3];
    int n;
    ids = '{2, 3, 0};
    n = 0;
    for (int i = 0; i < N; i++) begin
      bus.req_dina[48*i +: 48] = rnd48();
      bus.req_dinb[48*i +: 48] = rnd48();
    end
    for (int c = 0; c < 9; c++) begin
      ena = !(c >= 2 && c < 5);
      bus.req_valid = (c == 0) ? 4'b0100 :
                      (c == 1) ? 4'b1000 :
                      (c < 6)  ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (!ena) begin
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 8'd0) begin
          errors++;
          $display("FAIL stall_quiet c%0d got %b/%b need 0/0", c,
                   bus.req_ready, bus.rsp_valid);
        end
      end
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.inflight} !==
          {exp_ready(), exp_rsp(), exp_infl()}) begin
        errors++;
        $display("FAIL stall c%0d got %b/%b/%0d need %b/%b/%0d", c,
                 bus.req_ready, bus.rsp_valid, bus.inflight,
                 exp_ready(), exp_rsp(), exp_infl());
      end
      if (exp_rsp() != '0) begin
        checks++;
        if (bus.rsp_dout !== exp_dout()) begin
          errors++;
          $display("FAIL stall_dout c%0d got %h need %h", c,
                   bus.rsp_dout, exp_dout());
        end
      end
      if (bus.rsp_valid != '0 && n < 3) begin
        checks++;
        if (bus.rsp_id !== 2'(ids[n])) begin
          errors++;
          $display("FAIL stall_order n%0d got %0d need %0d", n,
                   bus.rsp_id, ids[n]);
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL stall_count got %0d need 3", n);
    end
    ena = 1'b1;
  endtask

  task automatic test_carry();
    ena = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_dina[47:0] = '1;
    bus.req_dinb[47:0] = '1;
    tick();
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_dout} !==
        {4'b0001, 49'h1_FFFF_FFFF_FFFE}) begin
      errors++;
      $display("FAIL carry got %b/%h need 0001/1fffffffffffe",
               bus.rsp_valid, bus.rsp_dout);
    end
    tick();
    ena_f = 1'b1;
    fbus.req_valid = 4'b0001;
    fbus.req_dina[47:0] = '1;
    fbus.req_dinb[47:0] = '1;
    @(negedge clk);
    checks++;
    if ({fbus.req_ready, fbus.rsp_valid} !== 8'b0001_0000) begin
      errors++;
      $display("FAIL fab_accept got %b/%b need 0001/0000",
               fbus.req_ready, fbus.rsp_valid);
    end
    tick();
    fbus.req_valid = '0;
    @(negedge clk);
    checks++;
    if ({fbus.rsp_valid, fbus.rsp_id, fbus.rsp_dout,
         fbus.inflight} !==
        {4'b0001, 2'd0, 49'h1_FFFF_FFFF_FFFE, 3'd1}) begin
      errors++;
      $display("FAIL fab_carry got %b/%0d/%h/%0d need 0001/0/1fffffffffffe/1",
               fbus.rsp_valid, fbus.rsp_id, fbus.rsp_dout,
               fbus.inflight);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({fbus.rsp_valid, fbus.inflight} !== 7'd0) begin
      errors++;
      $display("FAIL fab_drain got %b/%0d need 0/0",
               fbus.rsp_valid, fbus.inflight);
    end
    ena_f = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] acc;
    acc = '0;
    for (int c = 0; c < 400; c++) begin
      ena = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
          bus.req_dina[48*i +: 48] = rnd48();
          bus.req_dinb[48*i +: 48] = rnd48();
        end else if ($urandom_range(0, 9) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.inflight} !==
          {exp_ready(), exp_rsp(), exp_infl()}) begin
        errors++;
        $display("FAIL rand c%0d got %b/%b/%0d need %b/%b/%0d", c,
                 bus.req_ready, bus.rsp_valid, bus.inflight,
                 exp_ready(), exp_rsp(), exp_infl());
      end
      checks++;
      if (bus.rsp_id !== exp_id()) begin
        errors++;
        $display("FAIL rand_id c%0d got %0d need %0d", c,
                 bus.rsp_id, exp_id());
      end
      if (exp_rsp() != '0) begin
        checks++;
        if (bus.rsp_dout !== exp_dout()) begin
          errors++;
          $display("FAIL rand_dout c%0d got %h need %h", c,
                   bus.rsp_dout, exp_dout());
        end
      end
      acc = bus.req_ready;
      tick();
    end
    ena = 1'b1;
    idle(3);
  endtask

  task automatic test_reset_midflight();
    ena = 1'b1;
    bus.req_valid = '1;
    tick();
    tick();
    checks++;
    if (bus.inflight !== 3'd2) begin
      errors++;
      $display("FAIL mid_inflight got %0d need 2", bus.inflight);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id,
         bus.inflight} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset got %b/%b/%0d/%0d need 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id,
               bus.inflight);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.inflight} !== 7'd0) begin
        errors++;
        $display("FAIL mid_stale c%0d got %b/%0d need 0/0", c,
                 bus.rsp_valid, bus.inflight);
      end
    end
    tick();
    bus.req_valid = 4'b1000;
    bus.req_dina[144 +: 48] = 48'h1234_5678_9ABC;
    bus.req_dinb[144 +: 48] = 48'h0FED_CBA9_8765;
    tick();
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_dout} !==
        {4'b1000, 2'd3, 49'h0_2222_2222_2221}) begin
      errors++;
      $display("FAIL mid_after got %b/%0d/%h need 1000/3/222222222221",
               bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
    end
    tick();
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_dina   = '0;
    bus.req_dinb   = '0;
    fbus.req_valid = '0;
    fbus.req_dina  = '0;
    fbus.req_dinb  = '0;
    test_reset();
    test_fairness();
    test_single();
    test_wrap();
    test_stall();
    test_carry();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/math_add_48_arb.md
Name: math_add_48_arb

Overview:
- Round-robin arbiter that time-shares one math_add_48 instance (48-bit adder, DSP or fabric) among NUM_REQ requesters.
- Accepts at most one operand pair per enabled cycle.
- Tags each accepted pair with its requester index and returns the 49-bit sum with a one-hot valid after the adder's fixed latency.
- Sits between the per-channel accumulate/offset stages and the shared DSP slice, to cut DSP usage.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- USE_FABRIC, 0, passed to the adder; 1 selects the fabric implementation.
- FLOP_INPUTS, 1, passed to the adder; adder latency LAT = 1 + FLOP_INPUTS cycles. Must be 0 when USE_FABRIC = 1; elaboration error otherwise.
- IDW, $clog2(NUM_REQ) (min 1), width of the requester index (derived).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  global clock enable; low freezes arbiter, tag pipeline and adder.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- req_dina  in  48*NUM_REQ  operand A; requester i uses bits [48*i+47 : 48*i].
- req_dinb  in  48*NUM_REQ  operand B; same packing as req_dina.
- rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle per result.
- rsp_id  out  IDW  index of the requester owning rsp_dout.
- rsp_dout  out  49  unsigned sum A+B, bit 48 = carry.
- inflight  out  IDW+1  number of accepted pairs not yet returned (saturates at LAT).

Behaviour:
- Reset (async assert, sync deassert):
  - rr_ptr = 0, tag pipeline valid bits = 0, rsp_valid = 0, rsp_id = 0, inflight = 0, req_ready = 0.
  - rsp_dout is don't-care while rsp_valid = 0.
  - rst also drives the adder's rst. Adder contents after reset are never exposed, because the tag valids are cleared.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit is the grant g.
  - req_ready[g] = ena. All other req_ready bits are 0.
  - No req_valid set, or ena = 0: all req_ready = 0.
- Transfer: occurs when req_valid[g] && req_ready[g].
  - Mux req_dina/req_dinb of g to the adder's dina/dinb.
  - Push {valid = 1, id = g} into a tag shift register of depth LAT.
  - rr_ptr <= (g + 1) mod NUM_REQ.
- No transfer with ena = 1: push {valid = 0}. rr_ptr unchanged.
- Adder ena = module ena. The tag pipeline advances only when ena = 1. Adder and tags therefore stay aligned across any stall pattern.
- Latency: a transfer on enabled cycle t gives rsp_valid on the cycle after the LAT-th enabled edge from t. With ena held high this is exactly LAT cycles.
- Response outputs:
  - rsp_valid[id] = tail.valid; all other bits 0.
  - rsp_id = tail.id when tail.valid, else held.
  - rsp_dout = adder dout.
  - While ena = 0, the response shows no new strobe: rsp_valid is forced to 0 during stall cycles and resumes when ena returns.
- No response backpressure. Requesters must sink every result.
- inflight = count of valid tags in the pipeline, updated on enabled edges.
- Request rules:
  - A requester holds req_valid and operands stable until accepted.
  - Dropping req_valid before acceptance is permitted; that request is simply not performed.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Reset mid-operation: all in-flight results are discarded; no rsp_valid is issued for them.
- Arithmetic: full 48+48 -> 49-bit unsigned. Signed users take bits [47:0] and ignore bit 48.

Test Plan:
- Single requester, default params: req 2 sends A=48'h0000_0000_0005, B=48'h0000_0000_0007 at cycle t. Response: rsp_valid=4'b0100, rsp_id=2, rsp_dout=49'h0_0000_0000_000C at cycle t+2; inflight goes 1,1,0.
- Carry: A=B=48'hFFFF_FFFF_FFFF -> rsp_dout=49'h1_FFFF_FFFF_FFFE. Run with USE_FABRIC=1, FLOP_INPUTS=0: same result at latency 1.
- Fairness: all 4 req_valid held high for 8 cycles with per-requester distinct operands. Grants are 0,1,2,3,0,1,2,3; responses return in the same order with matching sums; no idle slot.
- Stall: ena low for 3 cycles between two back-to-back transfers. req_ready stays 0 during the stall; rsp_valid stays 0 during the stall; both results return correctly and in order after ena resumes.
- Pointer wrap and skip: rr_ptr=3, only req 1 valid -> req 1 granted, rr_ptr becomes 2. Next cycle reqs 1 and 3 valid -> req 3 granted first.
- Reset mid-flight: assert rst asynchronously while 2 results are in flight. Outputs go to reset values immediately; no stale rsp_valid after release; the next request returns its correct sum.
